f8_pipe_adder: RTL and testbench



---
 rtl/f8_pipe_adder_pkg.sv | 17 +
 rtl/f8_add_chunk.sv | 15 +
 rtl/f8_pipe_adder.sv | 121 ++++++++++++
 tb/tb_f8_pipe_adder.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/f8_pipe_adder_pkg.sv
// Shared definitions for the pipelined adder:
// mode encodings and chunk geometry helpers.
package f8_pipe_adder_pkg;

    localparam logic ADD = 1'b0;
    localparam logic SUB = 1'b1;

    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit width_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width)
            && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/f8_add_chunk.sv
// Combinational W-bit ripple chunk of the pipelined adder.
// One instance per pipeline stage.
module f8_add_chunk #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/f8_pipe_adder.sv
// Pipelined WIDTH-bit add/subtract, one chunk per stage,
// valid/ready on both sides with a single global advance.
module f8_pipe_adder
    import f8_pipe_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int CHUNK = chunk_w(WIDTH, STAGES);

    if (!width_ok(WIDTH, STAGES)) begin : g_bad_cfg
        $error("f8_pipe_adder: WIDTH must be a multiple of STAGES");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] cy_q;
    logic [STAGES-1:0] as_q;
    logic [STAGES-1:0] bs_q;
    logic [WIDTH-1:0]  d_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];

    logic [STAGES-1:0] v_i;
    logic [STAGES-1:0] cy_i;
    logic [STAGES-1:0] as_i;
    logic [STAGES-1:0] bs_i;
    logic [STAGES-1:0] cy_o;
    logic [WIDTH-1:0]  d_i [STAGES];
    logic [WIDTH-1:0]  b_i [STAGES];
    logic [WIDTH-1:0]  d_n [STAGES];
    logic [CHUNK-1:0]  ps  [STAGES];

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign b_eff    = (sub == SUB) ? ~b : b;
    assign cin_eff  = (sub == SUB) ? 1'b1 : c_in;

    // d carries {unconsumed a chunks, finished sum chunks}
    always_comb begin
        v_i[0]  = in_valid && in_ready;
        d_i[0]  = a;
        b_i[0]  = b_eff;
        cy_i[0] = cin_eff;
        as_i[0] = a[WIDTH-1];
        bs_i[0] = b_eff[WIDTH-1];
        for (int s = 1; s < STAGES; s++) begin
            v_i[s]  = v_q[s-1];
            d_i[s]  = d_q[s-1];
            b_i[s]  = b_q[s-1];
            cy_i[s] = cy_q[s-1];
            as_i[s] = as_q[s-1];
            bs_i[s] = bs_q[s-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stg
        f8_add_chunk #(
            .W (CHUNK)
        ) u_add (
            .a    (d_i[g][g*CHUNK +: CHUNK]),
            .b    (b_i[g][g*CHUNK +: CHUNK]),
            .cin  (cy_i[g]),
            .s    (ps[g]),
            .cout (cy_o[g])
        );
    end

    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            d_n[s] = d_i[s];
            d_n[s][s*CHUNK +: CHUNK] = ps[s];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q  <= '0;
            cy_q <= '0;
            as_q <= '0;
            bs_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                d_q[s] <= '0;
                b_q[s] <= '0;
            end
        end else if (adv) begin
            v_q  <= v_i;
            cy_q <= cy_o;
            as_q <= as_i;
            bs_q <= bs_i;
            for (int s = 0; s < STAGES; s++) begin
                d_q[s] <= d_n[s];
                b_q[s] <= b_i[s];
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign sum       = d_q[STAGES-1];
    assign c_out     = cy_q[STAGES-1];
    assign ovf       = (as_q[STAGES-1] == bs_q[STAGES-1])
                    && (sum[WIDTH-1] != as_q[STAGES-1]);

endmodule

// File: tb/tb_f8_pipe_adder.sv
// Self-checking bench for f8_pipe_adder (32/4 and 4/1 configs).
// Table vectors, directed corner sequences and random scoreboard.
module tb_f8_pipe_adder;

    localparam int W  = 32;
    localparam int ST = 4;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        o;
        int          stamp;
    } exp_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic        sb;
        logic [31:0] s;
        logic        c;
        logic        o;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         c_in = 1'b0;
    logic         sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;

    logic         in_valid1 = 1'b0;
    logic         in_ready1;
    logic [3:0]   a1 = '0;
    logic [3:0]   b1 = '0;
    logic         c_in1 = 1'b0;
    logic         sub1 = 1'b0;
    logic         out_valid1;
    logic         out_ready1 = 1'b1;
    logic [3:0]   sum1;
    logic         c_out1;
    logic         ovf1;

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   lat_chk = 1'b0;
    exp_t cur_exp;
    exp_t sb_q[$];
    exp_t mon_e;
    bit   stall_prev = 1'b0;
    logic [31:0] hold_s;
    logic hold_c;
    logic hold_o;
    vec_t tbl[10];

    f8_pipe_adder #(
        .WIDTH  (W),
        .STAGES (ST)
    ) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out),
        .ovf       (ovf)
    );

    f8_pipe_adder #(
        .WIDTH  (4),
        .STAGES (1)
    ) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .c_in      (c_in1),
        .sub       (sub1),
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .c_out     (c_out1),
        .ovf       (ovf1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain unsigned/signed arithmetic on the operands
    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                   input logic ci, input logic sb);
        exp_t m;
        logic [32:0] u;
        longint r;
        if (sb) begin
            u = {1'b0, x} - {1'b0, y};
            m.c = (x >= y);
            r = longint'($signed(x)) - longint'($signed(y));
        end else begin
            u = {1'b0, x} + {1'b0, y} + {32'd0, ci};
            m.c = u[32];
            r = longint'($signed(x)) + longint'($signed(y)) + longint'(ci);
        end
        m.s = u[31:0];
        m.o = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        m.stamp = 0;
        return m;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom % 6)
            0: return 32'hFFFF_FFFF;
            1: return 32'h8000_0000;
            2: return 32'h7FFF_FFFF;
            3: return 32'($urandom % 4);
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", nm, got, want);
        end
    endtask

    task automatic new_rand();
        a = pick();
        b = pick();
        c_in = 1'($urandom);
        sub = 1'($urandom);
        cur_exp = model(a, b, c_in, sub);
        in_valid = 1'b1;
    endtask

    task automatic wait_empty(input string nm);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 64 && !done; i++) begin
            @(posedge clk);
            #2;
            if (sb_q.size() == 0 && !out_valid) done = 1'b1;
        end
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s_drain: queue=%0d out_valid=%b, want 0/0",
                     nm, sb_q.size(), out_valid);
        end
    endtask

    task automatic wait_valid(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL %s_wait: out_valid got 0, want 1", nm);
        end
    endtask

    // Scoreboard: inspect at negedge what the next posedge will do
    always @(negedge clk) begin
        if (!reset) begin
            stall_prev = 1'b0;
        end else begin
            n_chk++;
            if (in_ready !== (!out_valid || out_ready)) begin
                n_fail++;
                $display("FAIL in_ready: got %b, want %b",
                         in_ready, !out_valid || out_ready);
            end
            if (stall_prev) begin
                n_chk++;
                if (out_valid !== 1'b1 || sum !== hold_s
                    || c_out !== hold_c || ovf !== hold_o) begin
                    n_fail++;
                    $display("FAIL hold: got v=%b %h/%b/%b, want 1 %h/%b/%b",
                             out_valid, sum, c_out, ovf,
                             hold_s, hold_c, hold_o);
                end
            end
            if (out_valid) begin
                n_chk++;
                if (sb_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL spurious: got out_valid=1 sum=%h, want no result",
                             sum);
                end else if (out_ready) begin
                    mon_e = sb_q.pop_front();
                    if (sum !== mon_e.s || c_out !== mon_e.c
                        || ovf !== mon_e.o) begin
                        n_fail++;
                        $display("FAIL result: got %h/%b/%b, want %h/%b/%b",
                                 sum, c_out, ovf, mon_e.s, mon_e.c, mon_e.o);
                    end
                    if (lat_chk) begin
                        n_chk++;
                        if (cyc - mon_e.stamp != ST) begin
                            n_fail++;
                            $display("FAIL latency: got %0d, want %0d",
                                     cyc - mon_e.stamp, ST);
                        end
                    end
                end
            end
            if (in_valid && in_ready) begin
                mon_e = cur_exp;
                mon_e.stamp = cyc;
                sb_q.push_back(mon_e);
            end
            stall_prev = out_valid && !out_ready;
            hold_s = sum;
            hold_c = c_out;
            hold_o = ovf;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        bit took;
        logic [31:0] s0;

        tbl[0] = '{32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0};
        tbl[1] = '{32'h5, 32'h7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
        tbl[2] = '{32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
        tbl[3] = '{32'h1, 32'h1, 1'b0, 1'b0, 32'h2, 1'b0, 1'b0};
        tbl[4] = '{32'h2, 32'h2, 1'b0, 1'b0, 32'h4, 1'b0, 1'b0};
        tbl[5] = '{32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
        tbl[6] = '{32'd10, 32'd0, 1'b1, 1'b0, 32'd11, 1'b0, 1'b0};
        tbl[7] = '{32'h3, 32'h3, 1'b1, 1'b1, 32'h0, 1'b1, 1'b0};
        tbl[8] = '{32'h0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0};
        tbl[9] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};

        #2 reset = 1'b0;
        #10;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_sum", sum, 32'd0);
        chk("rst_c_out", 32'(c_out), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst1_out_valid", 32'(out_valid1), 32'd0);
        chk("rst1_in_ready", 32'(in_ready1), 32'd1);
        @(posedge clk);
        #1 reset = 1'b1;

        // Table vectors streamed back to back, latency checked
        lat_chk = 1'b1;
        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            a = tbl[i].a;
            b = tbl[i].b;
            c_in = tbl[i].ci;
            sub = tbl[i].sb;
            cur_exp = '{tbl[i].s, tbl[i].c, tbl[i].o, 0};
            in_valid = 1'b1;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_empty("table");
        lat_chk = 1'b0;

        // Backpressure: fill four, stall five cycles, fifth held upstream
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 new_rand();
        end
        @(negedge clk);
        s0 = sum;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_sum", sum, s0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_empty("bp");

        // Reset with three transactions in flight
        @(posedge clk);
        #1 out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 new_rand();
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_valid("mid_rst");
        #2 reset = 1'b0;
        #1;
        chk("mr_out_valid", 32'(out_valid), 32'd0);
        chk("mr_in_ready", 32'(in_ready), 32'd1);
        chk("mr_sum", sum, 32'd0);
        sb_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("mr_quiet", 32'(out_valid), 32'd0);
        end
        lat_chk = 1'b1;
        @(posedge clk);
        #1 new_rand();
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_empty("mr_new");
        lat_chk = 1'b0;

        // Random in_valid/out_ready with upstream hold
        acc = 0;
        took = 1'b0;
        for (int k = 0; k < 40000 && acc < 10000; k++) begin
            @(posedge clk);
            #1;
            if (took || !in_valid) begin
                if (($urandom % 10) < 7) new_rand();
                else in_valid = 1'b0;
            end
            out_ready = ($urandom % 10) < 7;
            @(negedge clk);
            took = in_valid && in_ready;
            if (took) acc++;
        end
        chk("rand_count", 32'(acc), 32'd10000);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_empty("rand");

        // WIDTH=4, STAGES=1 registered full adder
        @(posedge clk);
        #1;
        a1 = 4'hF;
        b1 = 4'h1;
        c_in1 = 1'b1;
        sub1 = 1'b0;
        in_valid1 = 1'b1;
        @(negedge clk);
        chk("w4_pre_valid", 32'(out_valid1), 32'd0);
        @(posedge clk);
        #1;
        a1 = 4'h7;
        b1 = 4'h1;
        c_in1 = 1'b0;
        @(negedge clk);
        chk("w4_a_valid", 32'(out_valid1), 32'd1);
        chk("w4_a_sum", 32'(sum1), 32'h1);
        chk("w4_a_c", 32'(c_out1), 32'd1);
        chk("w4_a_ovf", 32'(ovf1), 32'd0);
        @(posedge clk);
        #1;
        a1 = 4'h0;
        b1 = 4'h1;
        sub1 = 1'b1;
        @(negedge clk);
        chk("w4_b_sum", 32'(sum1), 32'h8);
        chk("w4_b_c", 32'(c_out1), 32'd0);
        chk("w4_b_ovf", 32'(ovf1), 32'd1);
        @(posedge clk);
        #1 in_valid1 = 1'b0;
        @(negedge clk);
        chk("w4_c_valid", 32'(out_valid1), 32'd1);
        chk("w4_c_sum", 32'(sum1), 32'hF);
        chk("w4_c_c", 32'(c_out1), 32'd0);
        chk("w4_c_ovf", 32'(ovf1), 32'd0);
        @(negedge clk);
        chk("w4_end_valid", 32'(out_valid1), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
